uart_rx_buffer: RTL and testbench
=================================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter CLK_DIV, default 651, meaning sysclk cycles per 16x oversample tick (9600 baud at 100 MHz); legal range 2..4095.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries; a power of two, 2..16.
REQ-003 sysclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 UART_RX  input  1  serial line, asynchronous to sysclk, idle high, 8N1 LSB-first.
REQ-006 rd_en  input  1  pop strobe from the peripheral bus read of the RX data register; one pop per sysclk cycle high.
REQ-007 err_clr  input  1  clears sticky error flags.
REQ-008 rd_data  output  8  FIFO head byte (show-ahead); 8'h00 when empty.
REQ-009 rx_valid  output  1  FIFO non-empty.
REQ-010 rx_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 frame_err  output  1  sticky: a stop bit was sampled low.
REQ-012 overrun  output  1  sticky: a good byte was dropped because the FIFO was full.
REQ-013 irq  output  1  interrupt request to the processor, equal to rx_valid OR frame_err OR overrun.

Function
REQ-014 UART_RX shall pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rxs.
REQ-015 The tick counter shall count 0..CLK_DIV-1 and wrap; tick is high for one cycle when count==CLK_DIV-1; the counter shall be forced to 0 in the cycle a start edge is detected.
REQ-016 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-017 IDLE: rxs==0 -> START, with the tick counter and the 4-bit subtick counter cleared.
REQ-018 START: on the 8th tick (mid start bit), rxs==0 -> DATA with subtick cleared; rxs==1 -> IDLE, counted as a false start with no flag and no byte.
REQ-019 DATA: every 16th tick, sample rxs into shift bit [index], LSB first; after bit 7 is sampled -> STOP.
REQ-020 STOP: on the 16th tick, rxs==1 -> push the byte and go to IDLE; rxs==0 -> set frame_err, discard the byte, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until rxs==1, then go to IDLE, so that a break does not retrigger reception.
REQ-022 Push latency: the byte shall appear on rd_data and rx_valid shall rise in the cycle after the stop-bit sample tick, if the FIFO was empty.
REQ-023 FIFO: circular buffer with read and write pointers; pointers wrap modulo FIFO_DEPTH.
REQ-024 rd_en while empty shall be ignored, with no pointer change and no error.
REQ-025 Push while full without a simultaneous pop: the byte is dropped, overrun is set, and the FIFO contents are unchanged.
REQ-026 Push and pop in the same cycle, including when full: both are performed, rx_count is unchanged, and no overrun occurs.
REQ-027 err_clr clears frame_err and overrun; if a set event occurs in the same cycle as err_clr, set wins.
REQ-028 rd_data shall be combinational from the head entry and the empty flag, with no read latency.

Reset
REQ-029 Reset shall asynchronously force: FSM to IDLE, all counters and pointers to 0, rx_count 0, rd_data 8'h00, rx_valid 0, frame_err 0, overrun 0, irq 0, and synchronizer flops to 1.
REQ-030 A reset asserted mid-frame shall abandon the frame; after release, reception restarts only on a fresh falling edge of rxs.

Verification (CLK_DIV=4, so 1 bit = 64 sysclk cycles)
REQ-031 Send 8'hA5 with a good stop bit -> rd_data 8'hA5, rx_valid=1, rx_count=1 one cycle after the stop-bit sample; irq=1; pulse rd_en -> rx_count=0, rd_data=8'h00, irq=0.
REQ-032 Pull UART_RX low for 20 cycles, then return high -> FSM returns to IDLE with no byte and no flags; a following 8'h3C frame is received correctly.
REQ-033 Send 8'hFF with the stop bit held low for 3 bit times -> frame_err=1, rx_count=0, one frame only; err_clr pulse -> frame_err=0.
REQ-034 Send 5 bytes 8'h01..8'h05 with no reads (FIFO_DEPTH=4) -> rx_count=4, overrun=1, and popping yields 01,02,03,04 in that order.
REQ-035 Fill the FIFO to full, then assert rd_en in the exact cycle a 5th byte pushes -> rx_count stays 4, overrun=0, and the head advances to 8'h02.
REQ-036 Assert reset during DATA bit 4, release it, then send 8'h5A -> only 8'h5A is received with no flags; all outputs read their reset values while reset is held.

Source files
------------

// File: rtl/uart_rx_buffer_if.sv
// Bus-side signal bundle for the UART receive buffer: serial input, read/clear
// strobes from the processor bus, and the data/status/interrupt outputs.
interface uart_rx_buffer_if;
    logic       UART_RX;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [4:0] rx_count;
    logic       frame_err;
    logic       overrun;
    logic       irq;

    modport master (
        output UART_RX, rd_en, err_clr,
        input  rd_data, rx_valid, rx_count, frame_err, overrun, irq
    );

    modport slave (
        input  UART_RX, rd_en, err_clr,
        output rd_data, rx_valid, rx_count, frame_err, overrun, irq
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with 16x oversampling feeding a small show-ahead FIFO,
// plus sticky framing/overrun flags and a combined interrupt request.
module uart_rx_buffer #(
    parameter int CLK_DIV    = 651,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    uart_rx_buffer_if.slave  rx_if
);
    localparam int CW = 12;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic          r_sync1, r_rxs;
    logic [1:0]    r_settle;
    logic          r_armed;
    logic [2:0]    r_state;
    logic [CW-1:0] r_tick_cnt;
    logic [3:0]    r_sub;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [4:0]    r_count;
    logic          r_frame_err, r_overrun;

    logic          w_tick, w_start, w_end, w_push, w_ferr_set;
    logic          w_empty, w_full, w_pop, w_wr, w_ovr_set;
    logic [7:0]    w_entry [FIFO_DEPTH];
    logic [7:0]    w_head;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx_if.UART_RX;
            r_rxs   <= r_sync1;
        end
    end

    // The synchronizer resets high, so the line is only trusted once the flops
    // have been refilled; arming on a real high level stops a line that is
    // already low at reset release from looking like a start edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != 2'd3)
                r_settle <= r_settle + 2'd1;
            if (r_settle == 2'd3 && r_rxs)
                r_armed <= 1'b1;
        end
    end

    assign w_tick     = (r_tick_cnt == CW'(CLK_DIV - 1));
    assign w_start    = (r_state == S_IDLE) && r_armed && !r_rxs;
    assign w_end      = w_tick && (r_sub == 4'd15);
    assign w_push     = (r_state == S_STOP) && w_end && r_rxs;
    assign w_ferr_set = (r_state == S_STOP) && w_end && !r_rxs;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            r_tick_cnt <= '0;
        else if (w_start || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + CW'(1);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sub     <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_START;
                        r_sub   <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_sub <= r_sub + 4'd1;
                        // Mid start bit: a high line here was only a glitch.
                        if (r_sub == 4'd7) begin
                            r_sub     <= 4'd0;
                            r_bit_idx <= 3'd0;
                            r_state   <= r_rxs ? S_IDLE : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_sub <= r_sub + 4'd1;
                        if (r_sub == 4'd15) begin
                            r_shift[r_bit_idx] <= r_rxs;
                            r_bit_idx          <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7)
                                r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_sub <= r_sub + 4'd1;
                        if (r_sub == 4'd15)
                            r_state <= r_rxs ? S_IDLE : S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rxs)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == 5'(FIFO_DEPTH));
    assign w_pop     = rx_if.rd_en && !w_empty;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [7:0] r_entry;
            always_ff @(posedge sysclk or posedge reset) begin
                if (reset)
                    r_entry <= 8'h00;
                else if (w_wr && (r_wr_ptr == AW'(gi)))
                    r_entry <= r_shift;
            end
            assign w_entry[gi] = r_entry;
        end
    endgenerate

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_pop)
                r_count <= r_count + 5'd1;
            else if (w_pop && !w_wr)
                r_count <= r_count - 5'd1;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set)
                r_frame_err <= 1'b1;
            else if (rx_if.err_clr)
                r_frame_err <= 1'b0;
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (rx_if.err_clr)
                r_overrun <= 1'b0;
        end
    end

    assign w_head           = w_entry[r_rd_ptr];
    assign rx_if.rd_data    = w_empty ? 8'h00 : w_head;
    assign rx_if.rx_valid   = !w_empty;
    assign rx_if.rx_count   = r_count;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.overrun    = r_overrun;
    assign rx_if.irq        = !w_empty || r_frame_err || r_overrun;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer at CLK_DIV=4 (64 sysclk cycles per bit), FIFO_DEPTH=4,
// using a byte-queue scoreboard filled as frames are driven and drained on reads.
module tb_uart_rx_buffer;
    logic sysclk = 1'b0;
    logic reset  = 1'b1;

    uart_rx_buffer_if bus ();

    uart_rx_buffer #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .rx_if  (bus)
    );

    always #5 sysclk = ~sysclk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic       exp_fe  = 1'b0;
    logic       exp_ovr = 1'b0;
    logic [7:0] head;

    // Drives start, data and the first 34 cycles of the stop bit; returns on the
    // negedge just before the DUT's stop-bit sample edge.
    task automatic drive_frame(input logic [7:0] d, input logic stop_v, input logic pop_at_push);
        bus.UART_RX = 1'b0;
        repeat (64) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            bus.UART_RX = d[i];
            repeat (64) @(negedge sysclk);
        end
        bus.UART_RX = stop_v;
        repeat (34) @(negedge sysclk);
        if (pop_at_push) begin
            bus.rd_en = 1'b1;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (stop_v) begin
            if (exp_q.size() < 4) exp_q.push_back(d);
            else                  exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
    endtask

    task automatic finish_frame(input int stop_cycles);
        repeat (stop_cycles - 35) @(negedge sysclk);
        bus.UART_RX = 1'b1;
        repeat (16) @(negedge sysclk);
    endtask

    task automatic pop_strobe();
        bus.rd_en = 1'b1;
        @(negedge sysclk);
        bus.rd_en = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        bus.UART_RX = 1'b1; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        total++; if (bus.rx_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.rx_count); end
        total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.rd_data); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rx_valid); end
        total++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus.frame_err, bus.overrun); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", bus.irq); end
        reset = 1'b0;
        repeat (20) @(negedge sysclk);
        $display("reset released");
    endtask

    task automatic test_single_byte();
        drive_frame(8'hA5, 1'b1, 1'b0);
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL a5_early_valid got=%b want=0", bus.rx_valid); end
        @(negedge sysclk);
        total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL a5_valid got=%b want=1", bus.rx_valid); end
        total++; if (bus.rd_data !== exp_q[0]) begin bad++; $display("FAIL a5_data got=%h want=%h", bus.rd_data, exp_q[0]); end
        total++; if (bus.rx_count !== 5'd1) begin bad++; $display("FAIL a5_count got=%0d want=1", bus.rx_count); end
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL a5_irq got=%b want=1", bus.irq); end
        finish_frame(64);
        $display("rx byte %h count=%0d", bus.rd_data, bus.rx_count);
        pop_strobe();
        void'(exp_q.pop_front());
        total++; if (bus.rx_count !== 5'd0 || bus.rd_data !== 8'h00) begin bad++; $display("FAIL a5_pop got=%0d/%h want=0/00", bus.rx_count, bus.rd_data); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL a5_pop_irq got=%b want=0", bus.irq); end
        pop_strobe();
        total++; if (bus.rx_count !== 5'd0 || bus.rx_valid !== 1'b0) begin bad++; $display("FAIL empty_pop got=%0d/%b want=0/0", bus.rx_count, bus.rx_valid); end
        $display("empty read ignored count=%0d", bus.rx_count);
    endtask

    task automatic test_false_start();
        bus.UART_RX = 1'b0;
        repeat (20) @(negedge sysclk);
        bus.UART_RX = 1'b1;
        repeat (100) @(negedge sysclk);
        total++; if (bus.rx_count !== 5'd0 || bus.frame_err !== 1'b0 || bus.irq !== 1'b0) begin bad++; $display("FAIL glitch got=%0d/%b/%b want=0/0/0", bus.rx_count, bus.frame_err, bus.irq); end
        drive_frame(8'h3C, 1'b1, 1'b0);
        @(negedge sysclk);
        finish_frame(64);
        total++; if (bus.rx_count !== 5'd1) begin bad++; $display("FAIL 3c_count got=%0d want=1", bus.rx_count); end
        total++; if (bus.rd_data !== exp_q[0] || bus.rd_data !== 8'h3C) begin bad++; $display("FAIL 3c_data got=%h want=%h", bus.rd_data, exp_q[0]); end
        $display("rx byte %h count=%0d", bus.rd_data, bus.rx_count);
        pop_strobe();
        void'(exp_q.pop_front());
    endtask

    task automatic test_frame_error();
        drive_frame(8'hFF, 1'b0, 1'b0);
        @(negedge sysclk);
        total++; if (bus.frame_err !== exp_fe) begin bad++; $display("FAIL ferr_set got=%b want=%b", bus.frame_err, exp_fe); end
        total++; if (bus.rx_count !== 5'd0 || bus.irq !== 1'b1) begin bad++; $display("FAIL ferr_state got=%0d/%b want=0/1", bus.rx_count, bus.irq); end
        finish_frame(192);
        repeat (200) @(negedge sysclk);
        total++; if (bus.rx_count !== 5'd0 || bus.frame_err !== 1'b1) begin bad++; $display("FAIL ferr_break got=%0d/%b want=0/1", bus.rx_count, bus.frame_err); end
        bus.err_clr = 1'b1;
        @(negedge sysclk);
        bus.err_clr = 1'b0;
        exp_fe = 1'b0;
        total++; if (bus.frame_err !== exp_fe || bus.irq !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b/%b want=0/0", bus.frame_err, bus.irq); end
        $display("frame error cleared");
    endtask

    task automatic test_overrun();
        for (int b = 1; b <= 5; b++) begin
            drive_frame(8'(b), 1'b1, 1'b0);
            @(negedge sysclk);
            total++; if (bus.rx_count !== 5'(exp_q.size())) begin bad++; $display("FAIL ovr_fill%0d got=%0d want=%0d", b, bus.rx_count, exp_q.size()); end
            finish_frame(64);
            $display("sent byte %h count=%0d", 8'(b), bus.rx_count);
        end
        total++; if (bus.rx_count !== 5'd4 || bus.overrun !== exp_ovr) begin bad++; $display("FAIL ovr_flag got=%0d/%b want=4/%b", bus.rx_count, bus.overrun, exp_ovr); end
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.rd_data !== exp_q[0] || bus.rd_data !== 8'(k + 1)) begin bad++; $display("FAIL ovr_pop%0d got=%h want=%h", k, bus.rd_data, exp_q[0]); end
            $display("pop %h", bus.rd_data);
            pop_strobe();
            void'(exp_q.pop_front());
        end
        total++; if (bus.rx_count !== 5'd0 || bus.irq !== 1'b1) begin bad++; $display("FAIL ovr_drained got=%0d/%b want=0/1", bus.rx_count, bus.irq); end
        bus.err_clr = 1'b1;
        @(negedge sysclk);
        bus.err_clr = 1'b0;
        exp_ovr = 1'b0;
        total++; if (bus.overrun !== exp_ovr) begin bad++; $display("FAIL ovr_clear got=%b want=0", bus.overrun); end
    endtask

    task automatic test_back_to_back();
        for (int b = 1; b <= 4; b++) begin
            drive_frame(8'(b), 1'b1, 1'b0);
            @(negedge sysclk);
            finish_frame(64);
        end
        total++; if (bus.rx_count !== 5'd4) begin bad++; $display("FAIL b2b_full got=%0d want=4", bus.rx_count); end
        drive_frame(8'h05, 1'b1, 1'b1);
        @(negedge sysclk);
        bus.rd_en = 1'b0;
        total++; if (bus.rx_count !== 5'd4 || bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_count got=%0d/%b want=4/0", bus.rx_count, bus.overrun); end
        total++; if (bus.rd_data !== exp_q[0] || bus.rd_data !== 8'h02) begin bad++; $display("FAIL b2b_head got=%h want=02", bus.rd_data); end
        finish_frame(64);
        for (int k = 0; k < 4; k++) begin
            head = exp_q.pop_front();
            total++; if (bus.rd_data !== head) begin bad++; $display("FAIL b2b_pop%0d got=%h want=%h", k, bus.rd_data, head); end
            $display("pop %h", bus.rd_data);
            pop_strobe();
        end
        total++; if (bus.rx_count !== 5'd0 || bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0d/%b want=0/0", bus.rx_count, bus.overrun); end
    endtask

    task automatic test_reset_midframe();
        drive_frame(8'h77, 1'b1, 1'b0);
        @(negedge sysclk);
        finish_frame(64);
        total++; if (bus.rx_count !== 5'd1) begin bad++; $display("FAIL mid_pre got=%0d want=1", bus.rx_count); end
        head = 8'hA5;
        bus.UART_RX = 1'b0;
        repeat (64) @(negedge sysclk);
        for (int i = 0; i < 5; i++) begin
            bus.UART_RX = head[i];
            repeat ((i == 4) ? 32 : 64) @(negedge sysclk);
        end
        reset = 1'b1;
        exp_q.delete(); exp_fe = 1'b0; exp_ovr = 1'b0;
        @(negedge sysclk);
        total++; if (bus.rx_count !== 5'd0 || bus.rd_data !== 8'h00 || bus.rx_valid !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%h/%b want=0/00/0", bus.rx_count, bus.rd_data, bus.rx_valid); end
        total++; if (bus.irq !== 1'b0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin bad++; $display("FAIL mid_reset_flags got=%b%b%b want=000", bus.irq, bus.frame_err, bus.overrun); end
        bus.UART_RX = 1'b1;
        repeat (10) @(negedge sysclk);
        reset = 1'b0;
        repeat (50) @(negedge sysclk);
        drive_frame(8'h5A, 1'b1, 1'b0);
        @(negedge sysclk);
        finish_frame(64);
        repeat (200) @(negedge sysclk);
        total++; if (bus.rx_count !== 5'(exp_q.size()) || bus.rd_data !== exp_q[0]) begin bad++; $display("FAIL mid_5a got=%0d/%h want=1/%h", bus.rx_count, bus.rd_data, exp_q[0]); end
        total++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin bad++; $display("FAIL mid_flags got=%b%b want=00", bus.frame_err, bus.overrun); end
        $display("rx byte %h count=%0d", bus.rd_data, bus.rx_count);
        pop_strobe();
        void'(exp_q.pop_front());
        total++; if (bus.rx_count !== 5'd0) begin bad++; $display("FAIL mid_end got=%0d want=0", bus.rx_count); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
